// File: rtl/fpint_pkg.sv
// Shared FP16 field constants and the FSM state type for the serial fp x int multiplier.
package fpint_pkg;

  localparam int EXP_W          = 5;
  localparam int FRAC_W         = 10;
  localparam int BIAS           = 15;
  localparam int EXP_MAX_FINITE = 30;

  localparam logic [14:0] SAT_MAG = 15'h7BFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    NORM = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/fp16_norm_round.sv
// Combinational normalise + round-to-nearest-even of an unsigned fixed-point product into FP16.
module fp16_norm_round
  import fpint_pkg::*;
#(
  parameter int ACC_W = 14
) (
  input  logic [ACC_W-1:0]  acc,
  input  logic [EXP_W-1:0]  exp,
  input  logic              sign,
  input  logic              zero,
  output logic [15:0]       result
);

  localparam int PW = $clog2(ACC_W);
  // Two spare zero bits below the accumulator keep guard/sticky slices legal for the smallest ACC_W.
  localparam int NW = ACC_W + 2;

  logic [PW-1:0]     lead;
  logic [PW-1:0]     shift;
  logic [NW-1:0]     norm;
  logic [FRAC_W:0]   mant;
  logic              guard;
  logic              sticky;
  logic              round_up;
  logic [FRAC_W+1:0] sum;
  logic              carry;
  logic [FRAC_W-1:0] frac;
  logic [6:0]        exp_sum;

  always_comb begin
    lead = '0;
    for (int i = 0; i < ACC_W; i++) begin
      if (acc[i]) lead = PW'(i);
    end
  end

  assign shift    = PW'(ACC_W - 1) - lead;
  assign norm     = {acc, 2'b00} << shift;
  assign mant     = norm[NW-1 -: FRAC_W+1];
  assign guard    = norm[NW-FRAC_W-2];
  assign sticky   = |norm[NW-FRAC_W-3:0];
  assign round_up = guard & (sticky | mant[0]);
  assign sum      = {1'b0, mant} + {{(FRAC_W+1){1'b0}}, round_up};
  assign carry    = sum[FRAC_W+1];
  // On carry-out the rounded mantissa is exactly 2.0, so the shifted fraction is all zeros.
  assign frac     = carry ? sum[FRAC_W:1] : sum[FRAC_W-1:0];
  assign exp_sum  = 7'(exp) + 7'(lead) + 7'(carry) - 7'd10;

  always_comb begin
    result = 16'h0000;
    if (zero) begin
      result = 16'h0000;
    end else if ((exp_sum > 7'(EXP_MAX_FINITE)) || (exp == 5'd31)) begin
      result = {sign, SAT_MAG};
    end else begin
      result = {sign, exp_sum[EXP_W-1:0], frac};
    end
  end

endmodule

// File: rtl/fp_int_mul_serial.sv
// Bit-serial FP16 x signed-integer multiplier: one magnitude bit per cycle, then a single normalise/round.
module fp_int_mul_serial
  import fpint_pkg::*;
#(
  parameter int INT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_fp,
  input  logic [INT_W-1:0] in_int,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_fp
);

  localparam int ACC_W = INT_W + 10;
  localparam int CW    = $clog2(INT_W);

  state_t           state_reg;
  state_t           state_next;
  logic             sign_reg;
  logic [EXP_W-1:0] exp_reg;
  logic [FRAC_W:0]  mant_reg;
  logic [INT_W-1:0] mag_reg;
  logic [ACC_W-1:0] acc_reg;
  logic [CW-1:0]    cnt_reg;
  logic             zero_reg;
  logic [15:0]      out_fp_reg;

  logic [INT_W-1:0] mag_next;
  logic             mul_last;
  logic [15:0]      norm_result;

  // Two's-complement negate; the most negative value maps to 2^(INT_W-1) as an unsigned magnitude.
  assign mag_next = in_int[INT_W-1] ? (~in_int + INT_W'(1)) : in_int;
  assign mul_last = (cnt_reg == CW'(INT_W - 1));
  assign out_fp   = out_fp_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = MUL;
      end
      MUL: begin
        if (mul_last) state_next = NORM;
      end
      NORM: begin
        state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_reg   <= 1'b0;
      exp_reg    <= '0;
      mant_reg   <= '0;
      mag_reg    <= '0;
      acc_reg    <= '0;
      cnt_reg    <= '0;
      zero_reg   <= 1'b0;
      out_fp_reg <= 16'h0000;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            sign_reg <= in_fp[15] ^ in_int[INT_W-1];
            exp_reg  <= in_fp[14:10];
            mant_reg <= {1'b1, in_fp[FRAC_W-1:0]};
            mag_reg  <= mag_next;
            acc_reg  <= '0;
            cnt_reg  <= '0;
            zero_reg <= (in_fp[14:10] == 5'd0) || (in_int == '0);
          end
        end
        MUL: begin
          if (mag_reg[cnt_reg]) begin
            acc_reg <= acc_reg + (ACC_W'(mant_reg) << cnt_reg);
          end
          cnt_reg <= cnt_reg + CW'(1);
        end
        NORM: begin
          out_fp_reg <= norm_result;
        end
        default: ;
      endcase
    end
  end

  fp16_norm_round #(
    .ACC_W (ACC_W)
  ) u_norm (
    .acc    (acc_reg),
    .exp    (exp_reg),
    .sign   (sign_reg),
    .zero   (zero_reg),
    .result (norm_result)
  );

endmodule

// File: tb/tb_fp_int_mul_serial.sv
// Scoreboard bench for fp_int_mul_serial: INT_W=4 instance for function/handshake/reset, INT_W=8 for throughput.
module tb_fp_int_mul_serial;

  typedef struct {
    logic [15:0] fp;
    int          iv;
    logic [15:0] want;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_fp = 16'h0000;
  logic [3:0]  in_int = 4'd0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_fp;

  logic        in_valid8 = 1'b0;
  logic        in_ready8;
  logic [15:0] in_fp8 = 16'h0000;
  logic [7:0]  in_int8 = 8'd0;
  logic        out_valid8;
  logic        out_ready8 = 1'b1;
  logic [15:0] out_fp8;

  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  txn_t sb4[$];
  txn_t sb8[$];
  txn_t mon4;
  txn_t mon8;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fp_int_mul_serial #(.INT_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_fp     (in_fp),
    .in_int    (in_int),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_fp    (out_fp)
  );

  fp_int_mul_serial #(.INT_W(8)) dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid8),
    .in_ready  (in_ready8),
    .in_fp     (in_fp8),
    .in_int    (in_int8),
    .out_valid (out_valid8),
    .out_ready (out_ready8),
    .out_fp    (out_fp8)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      check_eq("sb4_nonempty", 32'(sb4.size() != 0), 32'd1);
      if (sb4.size() != 0) begin
        mon4 = sb4.pop_front();
        $display("txn w4 fp=%h int=%0d out=%h expected=%h", mon4.fp, mon4.iv, out_fp, mon4.want);
        check_eq("result4", 32'(out_fp), 32'(mon4.want));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && out_valid8 && out_ready8) begin
      check_eq("sb8_nonempty", 32'(sb8.size() != 0), 32'd1);
      if (sb8.size() != 0) begin
        mon8 = sb8.pop_front();
        $display("txn w8 fp=%h int=%0d out=%h expected=%h", mon8.fp, mon8.iv, out_fp8, mon8.want);
        check_eq("result8", 32'(out_fp8), 32'(mon8.want));
      end
    end
  end

  // hold: cycles of out_ready=0 once the result appears; pulse: assert in_valid mid-multiply.
  task automatic run_op(input logic [15:0] fp, input logic [3:0] iv, input logic [15:0] want,
                        input int hold, input bit pulse);
    int   k;
    txn_t t;
    out_ready = (hold == 0);
    k = 0;
    while (!in_ready && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    check_eq("accept_ready", 32'(in_ready), 32'd1);
    in_fp    = fp;
    in_int   = iv;
    in_valid = 1'b1;
    @(posedge clk);
    t.fp   = fp;
    t.iv   = int'($signed(iv));
    t.want = want;
    sb4.push_back(t);
    #1 in_valid = 1'b0;
    k = 0;
    while (!out_valid && k < 20) begin
      @(negedge clk);
      k++;
      if (pulse && k == 1) begin
        in_valid = 1'b1;
        in_fp    = 16'h4000;
        in_int   = 4'd2;
      end
      if (pulse && k == 2) begin
        check_eq("ready_in_mul", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
      end
    end
    check_eq("latency", 32'(k), 32'd6);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check_eq("bp_out_fp", 32'(out_fp), 32'(want));
      check_eq("bp_out_valid", 32'(out_valid), 32'd1);
      check_eq("bp_in_ready", 32'(in_ready), 32'd0);
    end
    if (hold > 0) begin
      @(posedge clk); #1 out_ready = 1'b1;
    end
    k = 0;
    while (out_valid && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    check_eq("done_exit", 32'(out_valid), 32'd0);
  endtask

  logic [15:0] v_fp   [13] = '{16'h3C00, 16'h3C00, 16'hBE00, 16'h3C01, 16'h3C03, 16'h3C01, 16'h3555,
                               16'h3D55, 16'h7BFF, 16'hFC00, 16'h0200, 16'hC000, 16'h4000};
  logic [3:0]  v_int  [13] = '{4'd3, 4'h8, 4'hD, 4'd3, 4'd3, 4'd7, 4'd7,
                               4'd3, 4'd3, 4'd1, 4'd5, 4'd0, 4'd5};
  logic [15:0] v_want [13] = '{16'h4200, 16'hC800, 16'h4480, 16'h4202, 16'h4204, 16'h4702, 16'h40AA,
                               16'h4400, 16'h7BFF, 16'hFBFF, 16'h0000, 16'h0000, 16'h4900};

  logic [15:0] f8 [3] = '{16'h3C00, 16'h3C00, 16'h4000};
  logic [7:0]  i8 [3] = '{8'd100, 8'h80, 8'hFF};
  logic [15:0] w8 [3] = '{16'h5640, 16'hD800, 16'hC000};
  int          acc_cyc [3];

  initial begin
    int   k;
    txn_t t;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_out_fp", 32'(out_fp), 32'd0);
    check_eq("rst_out_valid8", 32'(out_valid8), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 13; i++) begin
      run_op(v_fp[i], v_int[i], v_want[i], 0, 1'b0);
    end

    run_op(16'h4000, 4'd3, 16'h4600, 10, 1'b0);
    run_op(16'h3C00, 4'd5, 16'h4500, 0, 1'b1);

    // Abort an operation halfway through MUL; it must leave no trace.
    in_fp    = 16'h3800;
    in_int   = 4'd6;
    in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check_eq("abort_out_valid", 32'(out_valid), 32'd0);
    check_eq("abort_in_ready", 32'(in_ready), 32'd1);
    check_eq("abort_out_fp", 32'(out_fp), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(16'h3800, 4'd6, 16'h4200, 0, 1'b0);

    in_fp8    = f8[0];
    in_int8   = i8[0];
    in_valid8 = 1'b1;
    for (int n = 0; n < 3; n++) begin
      k = 0;
      while (!in_ready8 && k < 40) begin
        @(negedge clk);
        k++;
      end
      check_eq("accept_ready8", 32'(in_ready8), 32'd1);
      @(posedge clk);
      t.fp   = f8[n];
      t.iv   = int'($signed(i8[n]));
      t.want = w8[n];
      sb8.push_back(t);
      #1;
      acc_cyc[n] = cyc;
      if (n < 2) begin
        in_fp8  = f8[n+1];
        in_int8 = i8[n+1];
      end else begin
        in_valid8 = 1'b0;
      end
    end
    check_eq("ii8_first", 32'(acc_cyc[1] - acc_cyc[0]), 32'd11);
    check_eq("ii8_second", 32'(acc_cyc[2] - acc_cyc[1]), 32'd11);

    k = 0;
    while (sb8.size() != 0 && k < 100) begin
      @(posedge clk);
      k++;
    end
    repeat (2) @(posedge clk);
    check_eq("sb8_drained", 32'(sb8.size()), 32'd0);
    check_eq("sb4_drained", 32'(sb4.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", n_errors, n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
